// File: rtl/latch_pkg.sv
// Shared definitions for the button latch bank consumer: state encoding,
// default sizing and a constant-evaluable ceil(log2) helper.
package latch_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_CLR_CYCLES = 2;
  localparam int CNT_W          = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESENT  = 3'd1,
    CLEAR    = 3'd2,
    WAIT_LOW = 3'd3,
    FLUSH    = 3'd4,
    WAIT_ALL = 3'd5
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a bus of independent asynchronous level inputs.
module sync_ff2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/latch_event_reader.sv
// Turns latched button bits into indexed valid/ready events, lowest index
// first, and pulses the matching latch reset once each event is accepted.
module latch_event_reader
  import latch_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES,
  parameter int IDX_W      = clog2((WIDTH > 2) ? WIDTH : 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] clr,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_idx,
  output logic             ev_multi,
  input  logic             flush,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CLR_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE_BIT  = WIDTH'(1);

  logic [WIDTH-1:0] qs;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] clr_q, clr_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             multi_q, multi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] low_idx;
  logic             others_set;

  sync_ff2 #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (q),
    .q_o   (qs)
  );

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (qs[i]) low_idx = IDX_W'(i);
    end
  end

  assign others_set = |(qs & ~(ONE_BIT << low_idx));

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    cnt_d   = cnt_q;

    // Flush wins from every state; a simultaneous handshake still completes
    // on the consumer side, but the bit is cleared by the flush pulse.
    if (flush) begin
      state_d = FLUSH;
      clr_d   = '1;
      valid_d = 1'b0;
      cnt_d   = CNT_INIT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|qs) begin
            state_d = PRESENT;
            valid_d = 1'b1;
            idx_d   = low_idx;
            multi_d = others_set;
          end
        end
        PRESENT: begin
          if (ev_ready) begin
            state_d = CLEAR;
            valid_d = 1'b0;
            clr_d   = ONE_BIT << idx_q;
            cnt_d   = CNT_INIT;
          end
        end
        CLEAR, FLUSH: begin
          if (cnt_q == '0) begin
            clr_d   = '0;
            state_d = (state_q == FLUSH) ? WAIT_ALL : WAIT_LOW;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          // A held button keeps re-setting its latch; wait for the release.
          if (!qs[idx_q]) state_d = IDLE;
        end
        WAIT_ALL: begin
          if (qs == '0) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          clr_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clr_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr      = clr_q;
  assign ev_valid = valid_q;
  assign ev_idx   = idx_q;
  assign ev_multi = multi_q;
  assign busy     = (state_q != IDLE);

endmodule
